dram_bus_responder: RTL and testbench
=====================================

Name: dram_bus_responder

Overview:
Synthesizable responder (slave) end of the single-cycle DRAM-style bus: o_rw / o_csn / o_address / o_data, with read data sampled by the initiator one clock after select. The block holds a small word-addressed RAM plus a control and status register pair, and it counts accepted writes. It raises a sticky protocol error when the initiator writes while RAM is locked. It sits on the initiator's bus and gives the bus-master logic and testbench a real target to talk to.

Parameters:
dwidth, 8, data word width
awidth, 4, address width; 2**awidth locations, the top two are registers

Ports:
i_ck  in  1  clock; all state updates on rising edge
i_rstn  in  1  reset, synchronous, active-low
i_rw  in  1  0 = write, 1 = read; meaningful only while i_csn = 0
i_csn  in  1  chip select, active-low
i_address  in  awidth  word address; may be z/x while i_csn = 1 and must be ignored then
i_data  in  dwidth  write data from initiator
o_data  out  dwidth  read data to initiator
o_data_oe  out  1  high while the responder is driving valid read data
o_irq  out  1  interrupt = STAT.err & CTRL.irq_en, registered

Behaviour:
- Register map, with N = 2**awidth:
  - 0..N-3: RAM words.
  - N-2 = CTRL: bit0 lock, bit1 irq_en, other bits read 0.
  - N-1 = STAT: bit0 err (sticky), bits[dwidth-1:1] wr_cnt.
- Access definition: every rising edge of i_ck with i_rstn = 1 and i_csn = 0 is exactly one access.
  - If i_csn is held low for k edges, that is k accesses using the address and rw present at each edge.
- Read path (combinational, zero latency):
  - When i_csn = 0, i_rw = 1 and i_rstn = 1: o_data = word[i_address] and o_data_oe = 1.
  - Data is therefore valid before the next edge, where the initiator samples it.
  - Otherwise o_data = 0 and o_data_oe = 0.
  - Reads never modify state.
- Write, RAM address:
  - If CTRL.lock = 0: word <= i_data and wr_cnt <= wr_cnt + 1 (wraps from 2**(dwidth-1)-1 to 0).
  - If CTRL.lock = 1: RAM unchanged, wr_cnt unchanged, STAT.err <= 1.
- Write, CTRL: CTRL <= i_data[1:0]. This is never blocked by lock, is not counted and is not an error.
- Write, STAT:
  - i_data[0] = 1 clears err (write-1-to-clear).
  - i_data[dwidth-1] = 1 clears wr_cnt.
  - Both may clear in the same write. Not counted, not an error.
- o_irq is registered: it updates on the edge after err or irq_en changes (1 cycle latency).
- Reset (i_rstn = 0 at an edge):
  - RAM, CTRL, STAT and o_irq all go to 0.
  - Reset wins over a simultaneous access; that access is discarded.
  - While i_rstn = 0, o_data = 0 and o_data_oe = 0 regardless of i_csn.
- Unknown i_rw while i_csn = 0: treat as read (matches the initiator's idle rw = 1); no state change.
- There is no internal state machine beyond the registers. The one-access-per-edge rule replaces a handshake; the initiator guarantees spacing.

Decomposition:
- Shared package dram_bus_pkg holds:
  - dwidth/awidth defaults.
  - CTRL/STAT address offsets as functions of awidth.
  - CTRL bit positions LOCK = 0 and IRQ_EN = 1.
  - STAT bit positions ERR = 0 and CNT_LSB = 1.
  - Clear-bit positions for STAT writes.
- One sub-module, dram_bus_ram: (N-2) x dwidth array with synchronous write enable, asynchronous read and synchronous clear on reset. Register decode, counter and error logic stay in the top.

Test Plan:
1. Reset, then read all 16 addresses → every word reads 8'h00; o_data_oe is 1 only on csn-low cycles; o_irq = 0.
2. Write 8'hA5 @3, 8'h3C @13, then read both → read data 8'hA5 and 8'h3C; STAT reads 8'h04 (wr_cnt = 2, err = 0).
3. Write CTRL = 8'h03, write 8'hFF @3 → RAM[3] stays 8'hA5; STAT.err = 1 and wr_cnt unchanged; o_irq goes high one cycle after err sets. Then write STAT = 8'h01 → err = 0 and o_irq falls one cycle later.
4. Hold csn low for 3 edges with rw = 0, address 5, data 8'h11/8'h22/8'h33 → RAM[5] = 8'h33; wr_cnt increments by 3.
5. 130 unlocked writes from cleared state → wr_cnt = 2 (wrap at 128). Then write STAT = 8'h80 → wr_cnt = 0 and err is untouched.
6. Assert i_rstn low on the same edge as a write of 8'h77 @2 → RAM[2] = 0 after reset, o_data_oe = 0 during reset, and all registers read 0 afterwards.

Source files
------------

// File: rtl/dram_bus_pkg.sv
// Shared definitions for the DRAM-style bus responder.
// Holds default widths, the register map helpers (CTRL/STAT sit at the
// top two word addresses), and the bit positions used inside CTRL and STAT.
package dram_bus_pkg;

  localparam int DWIDTH = 8;
  localparam int AWIDTH = 4;

  // CTRL bit positions
  localparam int LOCK   = 0;
  localparam int IRQ_EN = 1;

  // STAT bit positions
  localparam int ERR     = 0;
  localparam int CNT_LSB = 1;

  // STAT write-1-to-clear positions: bit0 clears err, MSB clears wr_cnt
  localparam int STAT_CLR_ERR = 0;

  // Kind of bus activity seen on the current edge
  typedef enum logic [1:0] {
    ACC_NONE  = 2'd0,
    ACC_READ  = 2'd1,
    ACC_WRITE = 2'd2
  } acc_e;

  function automatic int stat_clr_cnt(input int dw);
    return dw - 1;
  endfunction

  function automatic int ctrl_addr(input int aw);
    return (2 ** aw) - 2;
  endfunction

  function automatic int stat_addr(input int aw);
    return (2 ** aw) - 1;
  endfunction

endpackage

// File: rtl/dram_bus_responder_if.sv
// Bus bundle between initiator (master) and responder (slave).
// Signals:
//   i_rw      0 = write, 1 = read (driven by initiator)
//   i_csn     active-low chip select (driven by initiator)
//   i_address word address (driven by initiator)
//   i_data    write data (driven by initiator)
//   o_data    read data (driven by responder)
//   o_data_oe responder is driving valid read data
interface dram_bus_responder_if
  import dram_bus_pkg::*;
#(
  parameter int dwidth = DWIDTH,
  parameter int awidth = AWIDTH
);

  logic              i_rw;
  logic              i_csn;
  logic [awidth-1:0] i_address;
  logic [dwidth-1:0] i_data;
  logic [dwidth-1:0] o_data;
  logic              o_data_oe;

  modport master (
    output i_rw, i_csn, i_address, i_data,
    input  o_data, o_data_oe
  );

  modport slave (
    input  i_rw, i_csn, i_address, i_data,
    output o_data, o_data_oe
  );

endinterface

// File: rtl/dram_bus_ram.sv
// Word storage for the responder: depth x dwidth registers with a
// synchronous write enable, asynchronous read and synchronous clear.
// Ports:
//   i_ck     clock
//   i_rstn   synchronous active-low clear of every word
//   i_we     write enable (caller already qualified address range)
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address; out-of-range addresses read 0
//   o_rdata  combinational read data
module dram_bus_ram #(
  parameter int dwidth = 8,
  parameter int awidth = 4,
  parameter int depth  = 14
) (
  input  logic              i_ck,
  input  logic              i_rstn,
  input  logic              i_we,
  input  logic [awidth-1:0] i_waddr,
  input  logic [dwidth-1:0] i_wdata,
  input  logic [awidth-1:0] i_raddr,
  output logic [dwidth-1:0] o_rdata
);

  // Sized to the full address space so the read index never goes out of range.
  logic [dwidth-1:0] words [2**awidth];

  genvar gi;
  generate
    for (gi = 0; gi < depth; gi++) begin : g_word
      logic [dwidth-1:0] word_q;
      logic [dwidth-1:0] word_d;

      always_comb begin
        word_d = word_q;
        if (i_we && (i_waddr == awidth'(gi))) begin
          word_d = i_wdata;
        end
      end

      always_ff @(posedge i_ck) begin
        if (!i_rstn) begin
          word_q <= '0;
        end else begin
          word_q <= word_d;
        end
      end

      assign words[gi] = word_q;
    end

    for (gi = depth; gi < 2**awidth; gi++) begin : g_pad
      assign words[gi] = '0;
    end
  endgenerate

  assign o_rdata = words[i_raddr];

endmodule

// File: rtl/dram_bus_responder.sv
// Responder end of the single-cycle DRAM-style bus.
// Every rising edge with i_rstn = 1 and i_csn = 0 is one access. Reads are
// combinational so data is valid before the edge the initiator samples on.
// Map: 0..N-3 RAM, N-2 CTRL {irq_en, lock}, N-1 STAT {wr_cnt, err}.
// Ports:
//   i_ck    clock
//   i_rstn  synchronous active-low reset
//   bus     slave side of the bus bundle
//   o_irq   registered STAT.err & CTRL.irq_en
module dram_bus_responder
  import dram_bus_pkg::*;
#(
  parameter int dwidth = DWIDTH,
  parameter int awidth = AWIDTH
) (
  input  logic                  i_ck,
  input  logic                  i_rstn,
  dram_bus_responder_if.slave   bus,
  output logic                  o_irq
);

  localparam int                NWORDS = (2 ** awidth) - 2;
  localparam logic [awidth-1:0] CTRL_A = awidth'(ctrl_addr(awidth));
  localparam logic [awidth-1:0] STAT_A = awidth'(stat_addr(awidth));
  localparam int                CLR_CNT = stat_clr_cnt(dwidth);

  logic [1:0]        ctrl_q, ctrl_d;
  logic              err_q, err_d;
  logic [dwidth-2:0] cnt_q, cnt_d;
  logic              irq_q, irq_d;

  acc_e              acc;
  logic              is_ram;
  logic              ram_we;
  logic [dwidth-1:0] ram_rdata;
  logic [dwidth-1:0] rd_word;

  // Classify the edge. An unknown rw or csn falls into the else branch, so
  // unknown rw is a read and unknown csn is no access.
  always_comb begin
    acc = ACC_NONE;
    if (i_rstn && (bus.i_csn == 1'b0)) begin
      if (bus.i_rw == 1'b0) begin
        acc = ACC_WRITE;
      end else begin
        acc = ACC_READ;
      end
    end
  end

  assign is_ram = (bus.i_address < CTRL_A);

  always_comb begin
    ctrl_d = ctrl_q;
    err_d  = err_q;
    cnt_d  = cnt_q;
    ram_we = 1'b0;
    if (acc == ACC_WRITE) begin
      if (is_ram) begin
        if (ctrl_q[LOCK]) begin
          err_d = 1'b1;
        end else begin
          ram_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end
      end else if (bus.i_address == CTRL_A) begin
        ctrl_d = bus.i_data[1:0];
      end else begin
        // Both clears may land in the same write.
        if (bus.i_data[STAT_CLR_ERR]) begin
          err_d = 1'b0;
        end
        if (bus.i_data[CLR_CNT]) begin
          cnt_d = '0;
        end
      end
    end
  end

  // Interrupt follows the current register values, one edge late.
  assign irq_d = err_q & ctrl_q[IRQ_EN];

  always_ff @(posedge i_ck) begin
    if (!i_rstn) begin
      ctrl_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
      irq_q  <= irq_d;
    end
  end

  dram_bus_ram #(
    .dwidth (dwidth),
    .awidth (awidth),
    .depth  (NWORDS)
  ) u_ram (
    .i_ck    (i_ck),
    .i_rstn  (i_rstn),
    .i_we    (ram_we),
    .i_waddr (bus.i_address),
    .i_wdata (bus.i_data),
    .i_raddr (bus.i_address),
    .o_rdata (ram_rdata)
  );

  always_comb begin
    rd_word = ram_rdata;
    if (bus.i_address == CTRL_A) begin
      rd_word = {{(dwidth-2){1'b0}}, ctrl_q};
    end else if (bus.i_address == STAT_A) begin
      rd_word = {cnt_q, err_q};
    end
  end

  assign bus.o_data    = (acc == ACC_READ) ? rd_word : '0;
  assign bus.o_data_oe = (acc == ACC_READ);
  assign o_irq         = irq_q;

endmodule

// File: tb/tb_dram_bus_responder.sv
// Directed bench for dram_bus_responder: inputs change on the falling edge,
// outputs are sampled 1 time unit after the rising or falling edge.
module tb_dram_bus_responder;

  logic i_ck;
  logic i_rstn;
  logic o_irq;

  int checks;
  int errors;

  dram_bus_responder_if #(.dwidth(8), .awidth(4)) bus ();

  dram_bus_responder #(.dwidth(8), .awidth(4)) dut (
    .i_ck   (i_ck),
    .i_rstn (i_rstn),
    .bus    (bus.slave),
    .o_irq  (o_irq)
  );

  initial i_ck = 1'b0;
  always #5 i_ck = ~i_ck;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One write access on the next rising edge; returns 1 unit after it.
  task automatic do_write(input logic [3:0] addr, input logic [7:0] data);
    @(negedge i_ck);
    bus.i_csn     = 1'b0;
    bus.i_rw      = 1'b0;
    bus.i_address = addr;
    bus.i_data    = data;
    @(posedge i_ck);
    #1;
    $display("WR addr=%0d data=%02h", addr, data);
  endtask

  // Present a read and check the combinational data before the edge.
  task automatic do_read(input logic [3:0] addr, input logic [7:0] exp, input string tag);
    @(negedge i_ck);
    bus.i_csn     = 1'b0;
    bus.i_rw      = 1'b1;
    bus.i_address = addr;
    #1;
    $display("RD addr=%0d data=%02h oe=%0b", addr, bus.o_data, bus.o_data_oe);
    check(tag, 32'(bus.o_data), 32'(exp));
    check({tag, "_oe"}, 32'(bus.o_data_oe), 32'd1);
  endtask

  task automatic idle_edge();
    @(negedge i_ck);
    bus.i_csn     = 1'b1;
    bus.i_rw      = 1'b1;
    bus.i_address = '0;
    bus.i_data    = '0;
    @(posedge i_ck);
    #1;
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    i_rstn        = 1'b0;
    bus.i_csn     = 1'b1;
    bus.i_rw      = 1'b1;
    bus.i_address = '0;
    bus.i_data    = '0;

    // 1. reset: selected read during reset drives nothing
    @(negedge i_ck);
    bus.i_csn = 1'b0;
    #1;
    check("rst_oe", 32'(bus.o_data_oe), 32'd0);
    check("rst_data", 32'(bus.o_data), 32'd0);
    @(negedge i_ck);
    bus.i_csn = 1'b1;
    i_rstn    = 1'b1;
    #1;
    check("rst_irq", 32'(o_irq), 32'd0);
    for (int a = 0; a < 16; a++) begin
      do_read(4'(a), 8'h00, "rst_read");
    end
    idle_edge();
    check("idle_oe", 32'(bus.o_data_oe), 32'd0);
    check("idle_data", 32'(bus.o_data), 32'd0);

    // 2. basic writes
    do_write(4'd3, 8'hA5);
    do_write(4'd13, 8'h3C);
    do_read(4'd3, 8'hA5, "ram3");
    do_read(4'd13, 8'h3C, "ram13");
    do_read(4'd15, 8'h04, "stat_cnt2");

    // 3. locked write raises err and, a cycle later, irq
    do_write(4'd14, 8'h03);
    do_read(4'd14, 8'h03, "ctrl_rd");
    do_write(4'd3, 8'hFF);
    check("irq_lag", 32'(o_irq), 32'd0);
    idle_edge();
    check("irq_set", 32'(o_irq), 32'd1);
    do_read(4'd3, 8'hA5, "ram3_locked");
    do_read(4'd15, 8'h05, "stat_err");
    do_write(4'd15, 8'h01);
    check("irq_hold", 32'(o_irq), 32'd1);
    idle_edge();
    check("irq_clr", 32'(o_irq), 32'd0);
    do_read(4'd15, 8'h04, "stat_errclr");
    do_write(4'd14, 8'h00);
    do_read(4'd14, 8'h00, "ctrl_unlock");

    // 4. three back-to-back write edges
    do_write(4'd5, 8'h11);
    do_write(4'd5, 8'h22);
    do_write(4'd5, 8'h33);
    do_read(4'd5, 8'h33, "burst_ram5");
    do_read(4'd15, 8'h0A, "burst_cnt5");

    // 5. counter wrap, then selective and combined clears
    do_write(4'd15, 8'h80);
    do_read(4'd15, 8'h00, "cnt_clr");
    for (int i = 0; i < 130; i++) begin
      do_write(4'd0, 8'(i));
    end
    do_read(4'd15, 8'h04, "cnt_wrap");
    do_read(4'd0, 8'h81, "ram0_last");
    do_write(4'd14, 8'h01);
    do_write(4'd1, 8'h99);
    do_write(4'd14, 8'h00);
    do_read(4'd15, 8'h05, "err_and_cnt");
    do_write(4'd15, 8'h80);
    do_read(4'd15, 8'h01, "cnt_clr_keep_err");
    do_write(4'd15, 8'h81);
    do_read(4'd15, 8'h00, "both_clr");

    // 6. reset collides with a write
    do_write(4'd14, 8'h03);
    do_write(4'd1, 8'h55);
    idle_edge();
    check("pre_rst_irq", 32'(o_irq), 32'd1);
    @(negedge i_ck);
    i_rstn        = 1'b0;
    bus.i_csn     = 1'b0;
    bus.i_rw      = 1'b0;
    bus.i_address = 4'd2;
    bus.i_data    = 8'h77;
    #1;
    check("rst_wr_oe", 32'(bus.o_data_oe), 32'd0);
    @(posedge i_ck);
    #1;
    check("rst_irq_low", 32'(o_irq), 32'd0);
    @(negedge i_ck);
    bus.i_rw      = 1'b1;
    bus.i_address = 4'd3;
    #1;
    check("rst_rd_oe", 32'(bus.o_data_oe), 32'd0);
    check("rst_rd_data", 32'(bus.o_data), 32'd0);
    @(negedge i_ck);
    i_rstn    = 1'b1;
    bus.i_csn = 1'b1;
    do_read(4'd2, 8'h00, "post_rst_ram2");
    do_read(4'd3, 8'h00, "post_rst_ram3");
    do_read(4'd5, 8'h00, "post_rst_ram5");
    do_read(4'd14, 8'h00, "post_rst_ctrl");
    do_read(4'd15, 8'h00, "post_rst_stat");
    idle_edge();
    check("post_rst_irq", 32'(o_irq), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
